mmc_discrete: RTL and testbench

//  Parametrised discrete-logic mapper covering iNES mappers 0 (NROM), 2 (UxROM), 3 (CNROM) and 7 (AxROM); the mode is taken from the header.

---
 rtl/mmc_discrete.sv | 228 ++++++++++++++++++++++
 tb/tb_mmc_discrete.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmc_discrete.sv
//==============================================================================
// Module      : mmc_discrete
// Description : Discrete-logic cartridge mapper for iNES 0/2/3/7 with PRG/CHR
//               request-ack sequencing. Optional BUS_CONFLICT_EN build ANDs
//               register writes with the ROM byte at the write address.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mmc_discrete #(
    parameter int PRGB = 5,
    parameter int CHRB = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] header,
    input  logic [15:0]  memaddr,
    input  logic [7:0]   memwdata,
    input  logic         memwr,
    input  logic         prgreq,
    output logic         prgack,
    output logic [7:0]   prgrdata,
    input  logic [13:0]  vmemaddr,
    input  logic         chrreq,
    output logic         chrack,
    output logic [7:0]   chrrdata,
    output logic [20:0]  promaddr,
    input  logic [7:0]   promdata,
    output logic         promreq,
    input  logic         promack,
    output logic [20:0]  cromaddr,
    input  logic [7:0]   cromdata,
    output logic         cromreq,
    input  logic         cromack,
    output logic [2:0]   mirr,
    output logic [7:0]   err
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROM = 2'd1, S_ACK = 2'd2} state_t;

    state_t            prg_state_q, prg_state_d, chr_state_q, chr_state_d;
    logic [7:0]        mode_q, err_q, mapper;
    logic [PRGB-1:0]   prg_bank_q;
    logic [PRGB-2:0]   ax_bank_q;
    logic              ax_mirr_q;
    logic [CHRB-1:0]   chr_bank_q;
    logic              prgack_q, prgack_d, chrack_q, chrack_d;
    logic              promreq_q, promreq_d, cromreq_q, cromreq_d;
    logic [7:0]        prgrdata_q, prgrdata_d, chrrdata_q, chrrdata_d;
    logic [20:0]       promaddr_q, promaddr_d, cromaddr_q, cromaddr_d;
    logic [20:0]       prg_mask, chr_mask, prg_raw, prg_map, chr_map;
    logic              supported, mapper_ok, bank_we;
    logic [7:0]        wr_val;
    logic              unused_ok;

    // Upper header bytes non-zero marks an old/dirty dump: ignore the high nibble.
    assign mapper    = {(|header[127:96]) ? 4'd0 : header[63:60], header[55:52]};
    assign mapper_ok = (mapper == 8'd0) || (mapper == 8'd2) || (mapper == 8'd3) || (mapper == 8'd7);
    assign supported = (mode_q == 8'd0) || (mode_q == 8'd2) || (mode_q == 8'd3) || (mode_q == 8'd7);

    // A 128-bank (2 MB) PRG size wraps to zero, so the mask becomes all ones.
    assign prg_mask = {header[38:32], 14'd0} - 21'd1;
    assign chr_mask = {header[47:40], 13'd0} - 21'd1;

    always_comb begin
        prg_raw = 21'(memaddr[14:0]);
        case (mode_q)
            8'd2:    prg_raw = memaddr[14] ? ((21'({PRGB{1'b1}}) << 14) | 21'(memaddr[13:0]))
                                           : ((21'(prg_bank_q) << 14) | 21'(memaddr[13:0]));
            8'd7:    prg_raw = (21'(ax_bank_q) << 15) | 21'(memaddr[14:0]);
            default: prg_raw = 21'(memaddr[14:0]);
        endcase
    end

    assign prg_map = prg_raw & prg_mask;
    assign chr_map = (((mode_q == 8'd3) ? (21'(chr_bank_q) << 13) : 21'd0)
                      | 21'(vmemaddr[12:0])) & chr_mask;

    always_comb begin
        prg_state_d = prg_state_q;
        prgack_d    = 1'b0;
        prgrdata_d  = prgrdata_q;
        promaddr_d  = promaddr_q;
        promreq_d   = promreq_q;
        bank_we     = 1'b0;
        wr_val      = memwdata;
        case (prg_state_q)
            S_IDLE: begin
                if (prgreq) begin
                    prg_state_d = S_ACK;
                    prgack_d    = 1'b1;
                    if (!supported) begin
                        prgrdata_d = 8'hFF;
                    end else if (!memaddr[15]) begin
                        prgrdata_d = 8'h00;
                    end else if (!memwr) begin
                        promaddr_d  = prg_map;
                        promreq_d   = 1'b1;
                        prg_state_d = S_ROM;
                        prgack_d    = 1'b0;
                    end else if (mode_q != 8'd0) begin
`ifdef BUS_CONFLICT_EN
                        promaddr_d  = prg_map;
                        promreq_d   = 1'b1;
                        prg_state_d = S_ROM;
                        prgack_d    = 1'b0;
`else
                        bank_we     = 1'b1;
`endif
                    end
                end
            end
            S_ROM: begin
                if (promack) begin
                    promreq_d   = 1'b0;
                    prg_state_d = S_ACK;
                    prgack_d    = 1'b1;
                    if (memwr) begin
                        bank_we = 1'b1;
                        wr_val  = memwdata & promdata;
                    end else begin
                        prgrdata_d = promdata;
                    end
                end
            end
            default: prg_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        chr_state_d = chr_state_q;
        chrack_d    = 1'b0;
        chrrdata_d  = chrrdata_q;
        cromaddr_d  = cromaddr_q;
        cromreq_d   = cromreq_q;
        case (chr_state_q)
            S_IDLE: begin
                if (chrreq) begin
                    chr_state_d = S_ACK;
                    chrack_d    = 1'b1;
                    if (!supported) begin
                        chrrdata_d = 8'hFF;
                    end else if (vmemaddr[13]) begin
                        chrrdata_d = 8'h00;
                    end else begin
                        cromaddr_d  = chr_map;
                        cromreq_d   = 1'b1;
                        chr_state_d = S_ROM;
                        chrack_d    = 1'b0;
                    end
                end
            end
            S_ROM: begin
                if (cromack) begin
                    cromreq_d   = 1'b0;
                    chrrdata_d  = cromdata;
                    chr_state_d = S_ACK;
                    chrack_d    = 1'b1;
                end
            end
            default: chr_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        mode_q <= mapper;
        if (reset) begin
            prg_state_q <= S_IDLE;
            chr_state_q <= S_IDLE;
            err_q       <= 8'd0;
            prg_bank_q  <= '0;
            ax_bank_q   <= '0;
            ax_mirr_q   <= 1'b0;
            chr_bank_q  <= '0;
            prgack_q    <= 1'b0;
            chrack_q    <= 1'b0;
            promreq_q   <= 1'b0;
            cromreq_q   <= 1'b0;
            prgrdata_q  <= 8'd0;
            chrrdata_q  <= 8'd0;
            promaddr_q  <= 21'd0;
            cromaddr_q  <= 21'd0;
        end else begin
            prg_state_q <= prg_state_d;
            chr_state_q <= chr_state_d;
            err_q       <= mapper_ok ? 8'd0 : mapper;
            prgack_q    <= prgack_d;
            chrack_q    <= chrack_d;
            promreq_q   <= promreq_d;
            cromreq_q   <= cromreq_d;
            prgrdata_q  <= prgrdata_d;
            chrrdata_q  <= chrrdata_d;
            promaddr_q  <= promaddr_d;
            cromaddr_q  <= cromaddr_d;
            if (bank_we) begin
                case (mode_q)
                    8'd2: prg_bank_q <= wr_val[PRGB-1:0];
                    8'd3: chr_bank_q <= wr_val[CHRB-1:0];
                    8'd7: begin
                        ax_bank_q <= wr_val[PRGB-2:0];
                        ax_mirr_q <= wr_val[4];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mirr = (mode_q == 8'd7) ? (ax_mirr_q ? 3'd3 : 3'd2)
                : header[51]        ? 3'd4
                : header[48]        ? 3'd1 : 3'd0;

    assign prgack   = prgack_q;
    assign chrack   = chrack_q;
    assign prgrdata = prgrdata_q;
    assign chrrdata = chrrdata_q;
    assign promaddr = promaddr_q;
    assign cromaddr = cromaddr_q;
    assign promreq  = promreq_q;
    assign cromreq  = cromreq_q;
    assign err      = err_q;

    assign unused_ok = ^{header[95:64], header[59:56], header[50:49], header[39],
                         header[31:0], wr_val};

endmodule

`default_nettype wire

// File: tb/tb_mmc_discrete.sv
//==============================================================================
// Module      : tb_mmc_discrete
// Description : Directed scoreboard bench for mmc_discrete (mappers 0/2/3/7/4).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mmc_discrete;

`ifdef BUS_CONFLICT_EN
    localparam logic BC = 1'b1;
`else
    localparam logic BC = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] header;
    logic [15:0]  memaddr;
    logic [7:0]   memwdata;
    logic         memwr, prgreq, prgack;
    logic [7:0]   prgrdata;
    logic [13:0]  vmemaddr;
    logic         chrreq, chrack;
    logic [7:0]   chrrdata;
    logic [20:0]  promaddr, cromaddr;
    logic [7:0]   promdata, cromdata;
    logic         promreq, promack, cromreq, cromack;
    logic [2:0]   mirr;
    logic [7:0]   err;

    always #5 clk = ~clk;

    mmc_discrete #(.PRGB(5), .CHRB(2)) dut (
        .clk(clk), .reset(reset), .header(header),
        .memaddr(memaddr), .memwdata(memwdata), .memwr(memwr),
        .prgreq(prgreq), .prgack(prgack), .prgrdata(prgrdata),
        .vmemaddr(vmemaddr), .chrreq(chrreq), .chrack(chrack), .chrrdata(chrrdata),
        .promaddr(promaddr), .promdata(promdata), .promreq(promreq), .promack(promack),
        .cromaddr(cromaddr), .cromdata(cromdata), .cromreq(cromreq), .cromack(cromack),
        .mirr(mirr), .err(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ROM models: fixed-latency responders returning a programmable byte.
    int          prom_hits = 0, crom_hits = 0, pcnt = 0, ccnt = 0;
    logic [20:0] seen_pa = '0, seen_ca = '0;
    logic [7:0]  prom_val = 8'h00, crom_val = 8'h00;
    logic        rom_hold = 1'b0;

    always @(posedge clk) begin
        promack <= 1'b0;
        if (promreq && !promack && !rom_hold) begin
            if (pcnt == 2) begin
                promack   <= 1'b1;
                promdata  <= prom_val;
                seen_pa   <= promaddr;
                prom_hits <= prom_hits + 1;
                pcnt      <= 0;
            end else pcnt <= pcnt + 1;
        end else pcnt <= 0;
    end

    always @(posedge clk) begin
        cromack <= 1'b0;
        if (cromreq && !cromack) begin
            if (ccnt == 3) begin
                cromack   <= 1'b1;
                cromdata  <= crom_val;
                seen_ca   <= cromaddr;
                crom_hits <= crom_hits + 1;
                ccnt      <= 0;
            end else ccnt <= ccnt + 1;
        end else ccnt <= 0;
    end

    typedef struct {
        logic [7:0]  rd;
        logic        chk_rd;
        logic [20:0] addr;
        logic        rom;
    } exp_t;

    exp_t prg_q[$];
    exp_t chr_q[$];

    function automatic logic [127:0] hdr(input logic [7:0] m, input logic [7:0] prg,
                                         input logic [7:0] chr, input logic [3:0] fl);
        logic [127:0] h;
        h          = '0;
        h[39:32]   = prg;
        h[47:40]   = chr;
        h[51:48]   = fl;
        h[55:52]   = m[3:0];
        h[63:60]   = m[7:4];
        return h;
    endfunction

    task automatic prg_op(input string tag, input logic [15:0] a, input logic wr,
                          input logic [7:0] wd, input logic [7:0] rd, input logic chk_rd,
                          input logic [20:0] pa, input logic rom);
        exp_t e;
        int   h0;
        logic got;
        e.rd = rd; e.chk_rd = chk_rd; e.addr = pa; e.rom = rom;
        prg_q.push_back(e);
        h0       = prom_hits;
        memaddr  = a;
        memwr    = wr;
        memwdata = wd;
        prgreq   = 1'b1;
        got      = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(posedge clk); #1;
            got = prgack;
        end
        prgreq = 1'b0;
        memwr  = 1'b0;
        e = prg_q.pop_front();
        chk({tag, ":prgack"}, 32'(got), 32'd1);
        if (got) begin
            if (e.chk_rd) chk({tag, ":prgrdata"}, 32'(prgrdata), 32'(e.rd));
            chk({tag, ":romaccess"}, 32'(prom_hits != h0), 32'(e.rom));
            if (e.rom) chk({tag, ":promaddr"}, 32'(seen_pa), 32'(e.addr));
            @(posedge clk); #1;
            chk({tag, ":ackpulse"}, 32'(prgack), 32'd0);
            if (e.chk_rd) chk({tag, ":rdhold"}, 32'(prgrdata), 32'(e.rd));
        end
    endtask

    task automatic chr_op(input string tag, input logic [13:0] a, input logic [7:0] rd,
                          input logic [20:0] ca, input logic rom);
        exp_t e;
        int   h0;
        logic got;
        e.rd = rd; e.chk_rd = 1'b1; e.addr = ca; e.rom = rom;
        chr_q.push_back(e);
        h0       = crom_hits;
        vmemaddr = a;
        chrreq   = 1'b1;
        got      = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(posedge clk); #1;
            got = chrack;
        end
        chrreq = 1'b0;
        e = chr_q.pop_front();
        chk({tag, ":chrack"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, ":chrrdata"}, 32'(chrrdata), 32'(e.rd));
            chk({tag, ":romaccess"}, 32'(crom_hits != h0), 32'(e.rom));
            if (e.rom) chk({tag, ":cromaddr"}, 32'(seen_ca), 32'(e.addr));
            @(posedge clk); #1;
            chk({tag, ":ackpulse"}, 32'(chrack), 32'd0);
        end
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic ackseen;
        reset = 1'b1; header = hdr(8'd0, 8'd1, 8'd1, 4'h1);
        memaddr = '0; memwdata = '0; memwr = 1'b0; prgreq = 1'b0;
        vmemaddr = '0; chrreq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst:prgack", 32'(prgack), 32'd0);
        chk("rst:chrack", 32'(chrack), 32'd0);
        chk("rst:promreq", 32'(promreq), 32'd0);
        chk("rst:cromreq", 32'(cromreq), 32'd0);
        chk("rst:prgrdata", 32'(prgrdata), 32'd0);
        chk("rst:chrrdata", 32'(chrrdata), 32'd0);
        chk("rst:promaddr", 32'(promaddr), 32'd0);
        chk("rst:cromaddr", 32'(cromaddr), 32'd0);
        chk("rst:err", 32'(err), 32'd0);
        reset = 1'b0;
        settle();
        chk("m0:mirr_vert", 32'(mirr), 32'd1);

        // NROM-128: $C005 mirrors down to offset 5
        prom_val = 8'h5A;
        prg_op("m0_rd", 16'hC005, 1'b0, 8'h00, 8'h5A, 1'b1, 21'h00005, 1'b1);
        prg_op("m0_wr", 16'h8000, 1'b1, 8'h33, 8'h00, 1'b0, 21'h0, 1'b0);
        prg_op("m0_low", 16'h0100, 1'b0, 8'h00, 8'h00, 1'b1, 21'h0, 1'b0);
        crom_val = 8'h3C;
        chr_op("m0_chr", 14'h1ABC, 8'h3C, 21'h01ABC, 1'b1);

        header = hdr(8'd2, 8'd8, 8'd1, 4'h0);
        settle();
        chk("m2:mirr_horiz", 32'(mirr), 32'd0);
        chk("m2:err", 32'(err), 32'd0);
        prom_val = 8'hFF;
        prg_op("m2_wr3", 16'h8000, 1'b1, 8'h03, 8'h00, 1'b0, 21'h00000, BC);
        prom_val = 8'h11;
        prg_op("m2_rd8010", 16'h8010, 1'b0, 8'h00, 8'h11, 1'b1, 21'h0C010, 1'b1);
        prom_val = 8'h22;
        prg_op("m2_rdC000", 16'hC000, 1'b0, 8'h00, 8'h22, 1'b1, 21'h1C000, 1'b1);
        prom_val = 8'h05;
        prg_op("m2_wr7", 16'h8000, 1'b1, 8'h07, 8'h00, 1'b0, 21'h0C000, BC);
        prom_val = 8'h44;
        prg_op("m2_bank", 16'h8000, 1'b0, 8'h00, 8'h44, 1'b1, BC ? 21'h14000 : 21'h1C000, 1'b1);

        header = hdr(8'd3, 8'd2, 8'd4, 4'h0);
        settle();
        prom_val = 8'hFF;
        prg_op("m3_wr2", 16'h8000, 1'b1, 8'h02, 8'h00, 1'b0, 21'h00000, BC);
        crom_val = 8'hC3;
        chr_op("m3_chr", 14'h0123, 8'hC3, 21'h04123, 1'b1);
        chr_op("m3_nt", 14'h2000, 8'h00, 21'h0, 1'b0);
        // Bank write racing a CHR read: the CHR address latches the old bank
        fork
            prg_op("m3_cwr", 16'h8000, 1'b1, 8'h01, 8'h00, 1'b0, 21'h00000, BC);
            chr_op("m3_cc", 14'h0001, 8'hC3, 21'h04001, 1'b1);
        join
        chr_op("m3_new", 14'h0001, 8'hC3, 21'h02001, 1'b1);

        header = hdr(8'd7, 8'd16, 8'd1, 4'h0);
        settle();
        prom_val = 8'hFF;
        prg_op("m7_wr15", 16'h8000, 1'b1, 8'h15, 8'h00, 1'b0, 21'h00000, BC);
        prom_val = 8'h66;
        prg_op("m7_rd", 16'h8000, 1'b0, 8'h00, 8'h66, 1'b1, 21'h28000, 1'b1);
        chk("m7:mirr_b", 32'(mirr), 32'd3);
        prom_val = 8'hFF;
        prg_op("m7_wr00", 16'h8000, 1'b1, 8'h00, 8'h00, 1'b0, 21'h28000, BC);
        chk("m7:mirr_a", 32'(mirr), 32'd2);

        header = hdr(8'd0, 8'd1, 8'd1, 4'h8);
        settle();
        chk("m0:mirr_four", 32'(mirr), 32'd4);

        header = hdr(8'd4, 8'd1, 8'd1, 4'h0);
        settle();
        chk("m4:err", 32'(err), 32'd4);
        prg_op("m4_rd", 16'h8000, 1'b0, 8'h00, 8'hFF, 1'b1, 21'h0, 1'b0);
        chr_op("m4_chr", 14'h0000, 8'hFF, 21'h0, 1'b0);

        header = hdr(8'd0, 8'd1, 8'd1, 4'h0);
        settle();
        chk("m0:err_clear", 32'(err), 32'd0);
        rom_hold = 1'b1;
        memaddr  = 16'h8000;
        memwr    = 1'b0;
        prgreq   = 1'b1;
        @(posedge clk); #1;
        chk("rstmid:promreq_hi", 32'(promreq), 32'd1);
        reset  = 1'b1;
        prgreq = 1'b0;
        @(posedge clk); #1;
        chk("rstmid:promreq_lo", 32'(promreq), 32'd0);
        ackseen = 1'b0;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            ackseen = ackseen | prgack;
        end
        chk("rstmid:no_ack", 32'(ackseen), 32'd0);
        rom_hold = 1'b0;
        prom_val = 8'h77;
        prg_op("post_rst", 16'h8001, 1'b0, 8'h00, 8'h77, 1'b1, 21'h00001, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
